// File: rtl/hpf_biquad_mc.sv
// hpf_biquad_mc: time-multiplexed biquad highpass, one shared MAC serving CH channels
// with per-channel history, frame-aligned cutoff select and sticky clip flags.
module hpf_biquad_mc #(
   parameter int W = 16,
   parameter int CW = 32,
   parameter int SHIFT = 30,
   parameter int CH = 2,
   parameter int CLEAR_ON_CHANGE = 1,
   localparam int CHW = CH > 1 ? $clog2(CH) : 1
) (
   input  logic                clk_48,
   input  logic                reset,
   input  logic [2:0]          filter,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CHW-1:0]      in_ch,
   input  logic signed [W-1:0] in_data,
   output logic                out_valid,
   output logic [CHW-1:0]      out_ch,
   output logic signed [W-1:0] out_data,
   output logic [CH-1:0]       clip_flags,
   input  logic                clip_clear
);
   localparam int AW = W + CW + 3;
   localparam logic signed [AW-1:0] YMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] YMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
   // rows: bypass, 100 Hz, 250 Hz, 500 Hz, 1 kHz; columns in tap order b0 b1 b2 a1 a2
   localparam logic signed [CW-1:0] COEF [5][5] = '{
      '{CW'(1) << SHIFT, '0, '0, '0, '0},
      '{CW'(1063845888), CW'(-2127691776), CW'(1063845888), CW'(2127609856), CW'(-1054048256)},
      '{CW'(1049231360), CW'(-2098462720), CW'(1049231360), CW'(2097676288), CW'(-1025245184)},
      '{CW'(1025245184), CW'(-2050490368), CW'(1025245184), CW'(2048131072), CW'(-978845696)},
      '{CW'(978845696), CW'(-1957691392), CW'(978845696), CW'(1949302784), CW'(-892338176)}
   };

   typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

   state_t state_q, state_d;
   logic [2:0] tap_q, tap_d, sel_q, sel_d, set_idx;
   logic [CHW-1:0] ch_q, ch_d, out_ch_q, out_ch_d;
   logic signed [W-1:0] x0_q, x0_d, out_data_q, out_data_d, opnd, y;
   logic signed [W-1:0] x1_q [CH], x1_d [CH], x2_q [CH], x2_d [CH];
   logic signed [W-1:0] y1_q [CH], y1_d [CH], y2_q [CH], y2_d [CH];
   logic signed [AW-1:0] acc_q, acc_d, sum, shr;
   logic signed [CW-1:0] coef;
   logic signed [W+CW-1:0] prod;
   logic sat_q, sat_d, out_valid_q, out_valid_d, hs, ch_ok, sat_hi, sat_lo;
   logic [CH-1:0] clip_q, clip_d;

   always_comb begin
      state_d = state_q;
      tap_d = tap_q;
      sel_d = sel_q;
      ch_d = ch_q;
      x0_d = x0_q;
      acc_d = acc_q;
      sat_d = sat_q;
      x1_d = x1_q;
      x2_d = x2_q;
      y1_d = y1_q;
      y2_d = y2_q;
      out_valid_d = 1'b0;
      out_ch_d = out_ch_q;
      out_data_d = out_data_q;
      in_ready = state_q != MAC;
      hs = in_valid && in_ready;
      ch_ok = int'(in_ch) < CH;
      set_idx = (sel_q != 3'd0 && sel_q <= 3'd4) ? sel_q : 3'd0;
      coef = COEF[set_idx][tap_q];
      opnd = tap_q == 3'd0 ? x0_q : tap_q == 3'd1 ? x1_q[ch_q] : tap_q == 3'd2 ? x2_q[ch_q] :
             tap_q == 3'd3 ? y1_q[ch_q] : y2_q[ch_q];
      prod = (W+CW)'(coef) * (W+CW)'(opnd);
      sum = (tap_q == 3'd0 ? '0 : acc_q) + AW'(prod);
      shr = sum >>> SHIFT;
      sat_hi = shr > YMAX;
      sat_lo = shr < YMIN;
      y = sat_hi ? {1'b0, {(W-1){1'b1}}} : sat_lo ? {1'b1, {(W-1){1'b0}}} : shr[W-1:0];
      clip_d = clip_clear ? '0 : clip_q;
      if (state_q == MAC) begin
         acc_d = sum;
         tap_d = tap_q + 3'd1;
         if (tap_q == 3'd4) begin
            state_d = WB;
            out_valid_d = 1'b1;
            out_ch_d = ch_q;
            out_data_d = y;
            sat_d = sat_hi || sat_lo;
         end
      end
      if (state_q == WB) begin
         state_d = IDLE;
         x2_d[ch_q] = x1_q[ch_q];
         x1_d[ch_q] = x0_q;
         y2_d[ch_q] = y1_q[ch_q];
         y1_d[ch_q] = out_data_q;
         if (sat_q) clip_d[ch_q] = 1'b1;
      end
      // a ch0 accept in the WB cycle may clear histories; the clear must override the writeback
      if (hs && ch_ok) begin
         state_d = MAC;
         tap_d = 3'd0;
         ch_d = in_ch;
         x0_d = in_data;
         if (in_ch == '0) begin
            sel_d = filter;
            if (CLEAR_ON_CHANGE != 0 && filter != sel_q) begin
               x1_d = '{default: '0};
               x2_d = '{default: '0};
               y1_d = '{default: '0};
               y2_d = '{default: '0};
            end
         end
      end
   end

   always_ff @(posedge clk_48) begin
      if (reset) begin
         state_q <= IDLE;
         tap_q <= '0;
         sel_q <= '0;
         ch_q <= '0;
         x0_q <= '0;
         acc_q <= '0;
         sat_q <= 1'b0;
         x1_q <= '{default: '0};
         x2_q <= '{default: '0};
         y1_q <= '{default: '0};
         y2_q <= '{default: '0};
         out_valid_q <= 1'b0;
         out_ch_q <= '0;
         out_data_q <= '0;
         clip_q <= '0;
      end else begin
         state_q <= state_d;
         tap_q <= tap_d;
         sel_q <= sel_d;
         ch_q <= ch_d;
         x0_q <= x0_d;
         acc_q <= acc_d;
         sat_q <= sat_d;
         x1_q <= x1_d;
         x2_q <= x2_d;
         y1_q <= y1_d;
         y2_q <= y2_d;
         out_valid_q <= out_valid_d;
         out_ch_q <= out_ch_d;
         out_data_q <= out_data_d;
         clip_q <= clip_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch = out_ch_q;
   assign out_data = out_data_q;
   assign clip_flags = clip_q;
endmodule

// File: tb/tb_hpf_biquad_mc.sv
// tb_hpf_biquad_mc: directed checks of the shared-MAC highpass with hand-computed outputs.
// CH=3 so that in_ch is 2 bits wide and an out-of-range index (3) can be driven.
module tb_hpf_biquad_mc;
   logic clk = 1'b0;
   logic reset, in_valid, clip_clear, in_ready, out_valid;
   logic [2:0] filter, clip_flags;
   logic [1:0] in_ch, out_ch;
   logic signed [15:0] in_data, out_data;
   int tests = 0, fails = 0;
   int y, lat, prev, pulses;

   always #5 clk = ~clk;

   hpf_biquad_mc #(.W(16), .CW(32), .SHIFT(30), .CH(3), .CLEAR_ON_CHANGE(1)) dut (
      .clk_48(clk), .reset(reset), .filter(filter), .in_valid(in_valid), .in_ready(in_ready),
      .in_ch(in_ch), .in_data(in_data), .out_valid(out_valid), .out_ch(out_ch),
      .out_data(out_data), .clip_flags(clip_flags), .clip_clear(clip_clear));

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // accept one sample; returns output value and edges from handshake to out_valid (0 = none)
   task automatic send(input int ch, input int d, input bit clr, output int yo, output int lo);
      @(negedge clk);
      in_valid = 1'b1;
      in_ch = 2'(ch);
      in_data = 16'(d);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lo = 0;
      yo = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lo = i;
            yo = int'(out_data);
            break;
         end
      end
      if (clr && lo != 0) begin
         clip_clear = 1'b1;
         @(posedge clk);
         #1 clip_clear = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; clip_clear = 1'b0; filter = 3'd0; in_ch = '0; in_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst in_ready", int'(in_ready), 1);
      check("rst out_valid", int'(out_valid), 0);
      check("rst out_data", int'(out_data), 0);
      check("rst out_ch", int'(out_ch), 0);
      check("rst clip", int'(clip_flags), 0);

      // bypass with exact cycle-level timing
      @(negedge clk);
      in_valid = 1'b1; in_ch = 2'd0; in_data = 16'sd1234;
      @(posedge clk);
      #1 in_valid = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         pulses += int'(in_ready) + int'(out_valid);
         if (i < 4) begin
            @(posedge clk);
            #1;
         end
      end
      check("byp busy window", pulses, 0);
      @(posedge clk);
      #1;
      check("byp out_valid", int'(out_valid), 1);
      check("byp out_data", int'(out_data), 1234);
      check("byp out_ch", int'(out_ch), 0);
      check("byp in_ready T+6", int'(in_ready), 1);
      @(posedge clk);
      #1;
      check("byp pulse width", int'(out_valid), 0);
      check("byp hold", int'(out_data), 1234);

      // 100 Hz step on ch0 interleaved with silent ch1
      filter = 3'd1;
      send(0, 10000, 0, y, lat); check("step0", y, 9907); check("step0 lat", lat, 5);
      send(1, 0, 0, y, lat); check("iso0", y, 0); check("iso0 ch", int'(out_ch), 1);
      send(0, 10000, 0, y, lat); check("step1", y, 9722); check("step1 ch", int'(out_ch), 0);
      send(1, 0, 0, y, lat); check("iso1", y, 0);
      send(0, 10000, 0, y, lat); check("step2", y, 9538);
      prev = y;
      for (int k = 0; k < 12; k++) begin
         send(0, 10000, 0, y, lat);
         check("step mono", int'(y < prev && y > 0), 1);
         prev = y;
         send(1, 0, 0, y, lat);
         check("iso", y, 0);
      end
      check("step no clip", int'(clip_flags), 0);

      // cutoff change on a ch1 accept waits for the next frame, then histories clear
      filter = 3'd4;
      send(1, 10000, 0, y, lat); check("sw ch1 old set", y, 9907);
      send(0, 10000, 0, y, lat); check("sw ch0 new set", y, 9116);
      send(1, 10000, 0, y, lat); check("sw ch1 cleared", y, 9116);

      // saturation and sticky clip flags
      pulse_reset();
      filter = 3'd1;
      for (int k = 0; k < 400; k++) send(0, -32768, 0, y, lat);
      @(negedge clk); clip_clear = 1'b1;
      @(posedge clk); #1 clip_clear = 1'b0;
      check("sat pre clear", int'(clip_flags), 0);
      send(0, 32767, 0, y, lat);
      check("sat pos", y, 32767);
      @(posedge clk); #1;
      check("sat flag set", int'(clip_flags), 1);
      for (int k = 0; k < 400; k++) send(0, 32767, 0, y, lat);
      check("sat flag sticky", int'(clip_flags), 1);
      @(negedge clk); clip_clear = 1'b1;
      @(posedge clk); #1 clip_clear = 1'b0;
      check("sat flag cleared", int'(clip_flags), 0);
      send(0, -32768, 1, y, lat);
      check("sat neg", y, -32768);
      check("sat set beats clear", int'(clip_flags), 1);

      // reset during MAC aborts the sample
      filter = 3'd0;
      @(negedge clk);
      in_valid = 1'b1; in_ch = 2'd0; in_data = 16'sd500;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("mrst in_ready", int'(in_ready), 1);
      check("mrst clip", int'(clip_flags), 0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         pulses += int'(out_valid);
         @(posedge clk); #1;
      end
      check("mrst no pulse", pulses, 0);
      send(0, -777, 0, y, lat); check("mrst byp", y, -777); check("mrst lat", lat, 5);

      // out-of-range channel is swallowed
      @(negedge clk);
      in_valid = 1'b1; in_ch = 2'd3; in_data = 16'sd1000;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("bad ch in_ready", int'(in_ready), 1);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         pulses += int'(out_valid);
         @(posedge clk); #1;
      end
      check("bad ch no pulse", pulses, 0);
      send(0, 4321, 0, y, lat); check("after bad ch", y, 4321); check("after bad ch out_ch", int'(out_ch), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
